// File: rtl/lfsr_fill_ctrl_if.sv
// Fill-controller bus: run request and stall from the master side,
// status and RAM write port from the controller (slave) side.
interface lfsr_fill_ctrl_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 6
);
    logic              start;
    logic [DATA_W-1:0] seed;
    logic [ADDR_W-1:0] len;
    logic              hold;
    logic              busy;
    logic              done;
    logic              en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    modport master (
        output start, seed, len, hold,
        input  busy, done, en, w_addr, w_data
    );

    modport slave (
        input  start, seed, len, hold,
        output busy, done, en, w_addr, w_data
    );
endinterface

// File: rtl/lfsr_fill_ctrl.sv
// LFSR RAM fill controller: writes len+1 pseudorandom words to addresses
// 0..len, one per unstalled cycle, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; registers hold their last values
// FILL  | one write per cycle while hold is low; LFSR and address advance
// DONE  | one-cycle done pulse, then back to IDLE unconditionally
module lfsr_fill_ctrl #(
    parameter int                DATA_W   = 12,
    parameter int                ADDR_W   = 6,
    parameter logic [DATA_W-1:0] SEED_ALT = 12'hACE
) (
    input  logic               clk,
    input  logic               rst_n,
    lfsr_fill_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] lfsr, lfsr_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] last, last_nxt;
    logic              feedback;

    // Taps 12,6,4,1 give a maximal-length sequence; an all-zero seed is
    // replaced by SEED_ALT so the register can never lock up at zero.
    assign feedback = lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: LFSR word, write address and captured last address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_ALT;
            addr <= '0;
            last <= '0;
        end else begin
            lfsr <= lfsr_nxt;
            addr <= addr_nxt;
            last <= last_nxt;
        end
    end

    // Next-state and datapath update; the address stops at last instead of
    // incrementing so a full-depth run never wraps back to zero.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        addr_nxt  = addr;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    lfsr_nxt  = (bus.seed == '0) ? SEED_ALT : bus.seed;
                    addr_nxt  = '0;
                    last_nxt  = bus.len;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (!bus.hold) begin
                    lfsr_nxt = {lfsr[DATA_W-2:0], feedback};
                    if (addr == last) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt = addr + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode from registers only; hold is the sole input that reaches
    // an output, so a stall suppresses the write in the same cycle.
    always_comb begin
        bus.en     = (state == FILL) && !bus.hold;
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
        bus.w_addr = addr;
        bus.w_data = lfsr;
    end

    // The LFSR must never reach the lock-up value.
    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        lfsr != '0);

    // Within a run the write address never passes the captured last address.
    a_addr_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (state == FILL) |-> (addr <= last));

endmodule

// File: tb/tb_lfsr_fill_ctrl.sv
// Directed bench for lfsr_fill_ctrl: fixed write sequences, stall, ignored
// restarts, async reset abort and a full LFSR period walk.
module tb_lfsr_fill_ctrl;

    logic clk;
    logic rst_n;

    lfsr_fill_ctrl_if #(.DATA_W(12), .ADDR_W(6)) dif ();

    lfsr_fill_ctrl #(.DATA_W(12), .ADDR_W(6), .SEED_ALT(12'hACE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0]  wa_q[$];
    logic [11:0] wd_q[$];
    int          done_at;
    int          done_cnt;
    logic [11:0] done_data;
    logic [5:0]  done_addr;
    logic [31:0] en_bits;
    logic        busy_end;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a run and record every write until a few cycles after done.
    // h0/h1 are FILL-cycle indices with hold high; poke re-pulses start in
    // FILL cycle 2 and in the DONE cycle.
    task automatic run_fill(input logic [11:0] s, input logic [5:0] l,
                            input int h0, input int h1, input bit poke);
        wa_q.delete();
        wd_q.delete();
        done_at  = -1;
        done_cnt = 0;
        en_bits  = '0;
        @(negedge clk);
        dif.start = 1'b1;
        dif.seed  = s;
        dif.len   = l;
        dif.hold  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            dif.start = poke && (c == 2);
            dif.hold  = (c == h0) || (c == h1);
            #1;
            if (c < 32) en_bits[c] = dif.en;
            if (dif.en) begin
                wa_q.push_back(dif.w_addr);
                wd_q.push_back(dif.w_data);
            end
            if (dif.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at   = c;
                    done_data = dif.w_data;
                    done_addr = dif.w_addr;
                end
                if (poke) dif.start = 1'b1;
            end
            if (done_at >= 0 && c >= done_at + 3) break;
        end
        busy_end  = dif.busy;
        dif.start = 1'b0;
        dif.hold  = 1'b0;
        if (done_at < 0) chk("run_timeout", 32'd0, 32'd1);
    endtask

    logic [11:0] exp5[5];
    logic [11:0] s_run;
    int          step;
    int          found;
    int          zero_seen;
    int          en_seen;
    int          busy_seen;

    initial begin
        exp5[0] = 12'h001; exp5[1] = 12'h003; exp5[2] = 12'h007;
        exp5[3] = 12'h00F; exp5[4] = 12'h01E;
        dif.start = 1'b0;
        dif.seed  = '0;
        dif.len   = '0;
        dif.hold  = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        chk("rst_en",     dif.en,     0);
        chk("rst_busy",   dif.busy,   0);
        chk("rst_done",   dif.done,   0);
        chk("rst_waddr",  dif.w_addr, 0);
        chk("rst_wdata",  dif.w_data, 12'hACE);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic run, started on the first edge after reset release.
        run_fill(12'h001, 6'd4, -1, -1, 1'b0);
        chk("basic_nwr", wa_q.size(), 5);
        for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
            chk("basic_addr", wa_q[i], i);
            chk("basic_data", wd_q[i], exp5[i]);
        end
        chk("basic_done_at",  done_at,  5);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_done_dat", done_data, 12'h03D);
        chk("basic_busy_end", busy_end, 0);

        // Zero seed substitutes SEED_ALT; len=0 is a single write.
        run_fill(12'h000, 6'd0, -1, -1, 1'b0);
        chk("zero_nwr", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            chk("zero_addr", wa_q[0], 0);
            chk("zero_data", wd_q[0], 12'hACE);
        end
        chk("zero_done_at", done_at, 1);

        // Stall in the 2nd and 3rd FILL cycles.
        run_fill(12'h001, 6'd4, 1, 2, 1'b0);
        chk("hold_nwr", wa_q.size(), 5);
        for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
            chk("hold_addr", wa_q[i], i);
            chk("hold_data", wd_q[i], exp5[i]);
        end
        chk("hold_en_c0", en_bits[0], 1);
        chk("hold_en_c1", en_bits[1], 0);
        chk("hold_en_c2", en_bits[2], 0);
        chk("hold_en_c3", en_bits[3], 1);
        chk("hold_done_at", done_at, 7);

        // Restart attempts during FILL and DONE are ignored.
        run_fill(12'h001, 6'd4, -1, -1, 1'b1);
        chk("poke_nwr",      wa_q.size(), 5);
        chk("poke_done_cnt", done_cnt, 1);
        chk("poke_done_at",  done_at, 5);
        chk("poke_busy_end", busy_end, 0);
        if (wd_q.size() > 2) chk("poke_data2", wd_q[2], 12'h007);

        // Asynchronous reset in the middle of a long run.
        @(negedge clk);
        dif.start = 1'b1;
        dif.seed  = 12'h001;
        dif.len   = 6'd63;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("abort_pre_en", dif.en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_en",    dif.en,     0);
        chk("abort_busy",  dif.busy,   0);
        chk("abort_waddr", dif.w_addr, 0);
        chk("abort_wdata", dif.w_data, 12'hACE);
        @(negedge clk);
        #1 rst_n = 1'b1;
        en_seen   = 0;
        busy_seen = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (dif.en)   en_seen++;
            if (dif.busy) busy_seen++;
        end
        chk("abort_no_wr",   en_seen,   0);
        chk("abort_no_busy", busy_seen, 0);

        // Full period: chain runs, seeding each from the word held after DONE.
        s_run     = 12'h001;
        step      = 0;
        found     = -1;
        zero_seen = 0;
        for (int r = 0; r < 64; r++) begin
            run_fill(s_run, 6'd63, -1, -1, 1'b0);
            if (r == 0) begin
                chk("full_nwr",       wa_q.size(), 64);
                chk("full_last_addr", (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 6'd0, 63);
                chk("full_done_addr", done_addr, 63);
            end
            foreach (wd_q[i]) begin
                if (wd_q[i] == 12'h000) zero_seen++;
                if (step > 0 && wd_q[i] == 12'h001 && found < 0) found = step;
                step++;
            end
            s_run = done_data;
        end
        chk("period",    found,     4095);
        chk("zero_seen", zero_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
